// File: rtl/distance_pkg.sv
// Shared definitions for the distance IP: FSM state encoding, counter widths
// and the timeout result code.
package distance_pkg;

    localparam int unsigned CYC_W = 21;
    localparam int unsigned SUB_W = 10;

    localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for an asynchronous input plus registered one-cycle
// rise/fall flags. A flag is high 3 clk after the raw edge.
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic level_dly;

    // Synchroniser, delayed copy and registered edge flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta      <= 1'b0;
            level     <= 1'b0;
            level_dly <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            meta      <= async_in;
            level     <= meta;
            level_dly <= level;
            rise      <= level & ~level_dly;
            fall      <= ~level & level_dly;
        end
    end

endmodule

// File: rtl/echo_width_meter.sv
// Measures echo high time after a start pulse and converts it to millimetres
// by counting whole CYC_PER_MM periods, rounding the remainder half up.
module echo_width_meter
    import distance_pkg::*;
#(
    parameter int unsigned CYC_PER_MM = 729,
    parameter int unsigned RISE_TO    = 1_249_999,
    parameter int unsigned MAX_MM     = 4000,
    parameter int unsigned DW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          echo,
    output logic          busy,
    output logic [DW-1:0] dist_mm,
    output logic          dist_valid,
    output logic          timeout
);

    state_t             state, state_d;
    logic [CYC_W-1:0]   cyc, cyc_d;
    logic [SUB_W-1:0]   sub, sub_d;
    logic [DW-1:0]      mm, mm_d;
    logic               busy_d;
    logic [DW-1:0]      dist_d;
    logic               valid_d;
    logic               to_d;

    logic               echo_rise;
    logic               echo_fall;
    logic               wrap_c;
    logic [DW-1:0]      mm_inc_c;

    echo_sync u_echo_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (echo),
        .level    (),
        .rise     (echo_rise),
        .fall     (echo_fall)
    );

    assign wrap_c   = (sub == SUB_W'(CYC_PER_MM - 1));
    assign mm_inc_c = mm + DW'(1);

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cyc        <= '0;
            sub        <= '0;
            mm         <= '0;
            busy       <= 1'b0;
            dist_mm    <= '0;
            dist_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_d;
            cyc        <= cyc_d;
            sub        <= sub_d;
            mm         <= mm_d;
            busy       <= busy_d;
            dist_mm    <= dist_d;
            dist_valid <= valid_d;
            timeout    <= to_d;
        end
    end

    // Next-state, counter and result logic
    always_comb begin
        state_d = state;
        cyc_d   = cyc;
        sub_d   = sub;
        mm_d    = mm;
        busy_d  = busy;
        dist_d  = dist_mm;
        valid_d = 1'b0;
        to_d    = timeout;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_RISE;
                    busy_d  = 1'b1;
                    cyc_d   = '0;
                    sub_d   = '0;
                    mm_d    = '0;
                end
            end

            WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                end else if (cyc == CYC_W'(RISE_TO)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    dist_d  = DW'(DIST_TIMEOUT);
                    to_d    = 1'b1;
                end else begin
                    cyc_d = cyc + CYC_W'(1);
                end
            end

            MEASURE: begin
                sub_d = wrap_c ? '0 : sub + SUB_W'(1);
                mm_d  = wrap_c ? mm_inc_c : mm;
                if (echo_fall) begin
                    // A wrap on the fall cycle is counted first; its remainder is zero
                    state_d = DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    to_d    = 1'b0;
                    dist_d  = wrap_c ? mm_inc_c
                                     : mm + DW'(sub >= SUB_W'(CYC_PER_MM / 2));
                end else if (wrap_c && (mm_inc_c == DW'(MAX_MM))) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    dist_d  = DW'(DIST_TIMEOUT);
                    to_d    = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
